// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that gives N_REQ requesters access to one single-port memory.
// Supports locked bursts of up to MAX_HOLD back-to-back accesses per grant.
module mem_bus_arbiter #(
   parameter int N_REQ    = 3,
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    lock,
   input  logic [N_REQ-1:0]    we,
   input  logic [N_REQ*AW-1:0] addr,
   input  logic [N_REQ*DW-1:0] wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    ack,
   output logic [DW-1:0]       rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata,
   output logic                busy
);

   localparam int LW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
   localparam logic [LW-1:0]  LAST_INIT = LW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_reg, state_next;
   logic [LW-1:0]     last_reg, last_next;
   logic [LW-1:0]     gidx_reg, gidx_next;
   logic [N_REQ-1:0]  gnt_reg, gnt_next;
   logic [HCW-1:0]    hold_reg, hold_next;
   logic              we_reg, we_next;
   logic [AW-1:0]     addr_reg, addr_next;
   logic [DW-1:0]     wdata_reg, wdata_next;

   logic [LW-1:0]     win_idx;
   logic              win_found;

   logic [AW-1:0]     addr_arr  [N_REQ];
   logic [DW-1:0]     wdata_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign addr_arr[gi]  = addr[gi*AW +: AW];
         assign wdata_arr[gi] = wdata[gi*DW +: DW];
      end
   endgenerate

   // Search upward from the requester after the last one served, wrapping around.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_reg) + k) % N_REQ;
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = LW'(idx);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      gidx_next  = gidx_reg;
      gnt_next   = gnt_reg;
      hold_next  = hold_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      case (state_reg)
         IDLE: begin
            if (win_found) begin
               state_next        = ACCESS;
               gidx_next         = win_idx;
               gnt_next          = '0;
               gnt_next[win_idx] = 1'b1;
               we_next           = we[win_idx];
               addr_next         = addr_arr[win_idx];
               wdata_next        = wdata_arr[win_idx];
            end
         end
         ACCESS: state_next = RESP;
         RESP: begin
            if (lock[gidx_reg] && req[gidx_reg] && (hold_reg < HOLD_LAST)) begin
               state_next = ACCESS;
               hold_next  = hold_reg + 1'b1;
               we_next    = we[gidx_reg];
               addr_next  = addr_arr[gidx_reg];
               wdata_next = wdata_arr[gidx_reg];
            end else begin
               state_next = IDLE;
               gnt_next   = '0;
               last_next  = gidx_reg;
               hold_next  = '0;
               we_next    = 1'b0;
               addr_next  = '0;
               wdata_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         last_reg  <= LAST_INIT;
         gidx_reg  <= '0;
         gnt_reg   <= '0;
         hold_reg  <= '0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         gidx_reg  <= gidx_next;
         gnt_reg   <= gnt_next;
         hold_reg  <= hold_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
      end
   end

   // Memory answers during RESP, so read data is passed straight through in the ack cycle.
   assign gnt       = gnt_reg;
   assign mem_en    = (state_reg == ACCESS);
   assign mem_we    = we_reg & mem_en;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign ack       = (state_reg == RESP) ? gnt_reg : '0;
   assign rdata     = (state_reg == RESP && !we_reg) ? mem_rdata : '0;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the memory model returns addr ^ 8'h4A one cycle after mem_en.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, lock, we;
   logic [23:0] addr, wdata;
   logic [2:0]  gnt, ack;
   logic [7:0]  rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_en, mem_we, busy;

   int tests  = 0;
   int failed = 0;

   mem_bus_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
      .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      mem_rdata <= mem_en ? (mem_addr ^ 8'h4A) : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("ack_in_gnt", 32'(ack & ~gnt), 32'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
   endtask

   task automatic chk_access(input string tag, input logic [2:0] g, input logic [7:0] a);
      chk({tag, "_gnt"}, 32'(gnt), 32'(g));
      chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
   endtask

   task automatic chk_resp(input string tag, input logic [2:0] g, input logic [7:0] rd);
      chk({tag, "_ack"}, 32'(ack), 32'(g));
      chk({tag, "_gnt"}, 32'(gnt), 32'(g));
      chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      chk({tag, "_rdata"}, 32'(rdata), 32'(rd));
   endtask

   initial begin
      reset = 1'b0; req = '0; lock = '0; we = '0;
      addr  = {8'h10, 8'h3C, 8'h01};
      wdata = {8'h00, 8'hA5, 8'h00};
      step(); step();
      chk_idle("reset");
      chk("reset_rdata", 32'(rdata), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_mem_we", 32'(mem_we), 32'd0);
      reset = 1'b1;
      step();
      chk_idle("idle_noreq");
      $display("[TB] reset done");

      // Round robin 0,1,2,0 with req held.
      req = 3'b111;
      step(); chk_access("rr0", 3'b001, 8'h01);
      step(); chk_resp("rr0", 3'b001, 8'h4B);
      step(); chk_idle("rr0_gap");
      step(); chk_access("rr1", 3'b010, 8'h3C);
      step(); chk_resp("rr1", 3'b010, 8'h76);
      step(); chk_idle("rr1_gap");
      step(); chk_access("rr2", 3'b100, 8'h10);
      step(); chk_resp("rr2", 3'b100, 8'h5A);
      step(); chk_idle("rr2_gap");
      step(); chk_access("rr3", 3'b001, 8'h01);
      step(); chk_resp("rr3", 3'b001, 8'h4B);
      req = 3'b000;
      step(); chk_idle("rr_end");
      $display("[TB] round robin sequence done");

      // Requester 1 write.
      req = 3'b010; we = 3'b010;
      step(); chk_access("wr", 3'b010, 8'h3C);
      chk("wr_mem_we", 32'(mem_we), 32'd1);
      chk("wr_mem_wdata", 32'(mem_wdata), 32'h0A5);
      step(); chk_resp("wr", 3'b010, 8'h00);
      chk("wr_resp_mem_we", 32'(mem_we), 32'd0);
      req = 3'b000; we = 3'b000;
      step(); chk_idle("wr_end");
      $display("[TB] write by requester 1 done");

      // Requester 2 read, ack two edges after req is sampled.
      req = 3'b100;
      step(); chk_access("rd", 3'b100, 8'h10);
      chk("rd_mem_we", 32'(mem_we), 32'd0);
      step(); chk_resp("rd", 3'b100, 8'h5A);
      req = 3'b000;
      step(); chk_idle("rd_end");
      $display("[TB] read by requester 2 done");

      // Locked burst by requester 0 limited to 4 accesses, then requester 1.
      req = 3'b011; lock = 3'b001;
      for (int i = 0; i < 4; i++) begin
         step(); chk_access($sformatf("lock%0d", i), 3'b001, 8'h01);
         step(); chk_resp($sformatf("lock%0d", i), 3'b001, 8'h4B);
      end
      step(); chk_idle("lock_release");
      step(); chk_access("lock_next", 3'b010, 8'h3C);
      step(); chk_resp("lock_next", 3'b010, 8'h76);
      req = 3'b000; lock = 3'b000;
      step(); chk_idle("lock_end");
      $display("[TB] locked burst done");

      // Reset during ACCESS abandons the transaction.
      req = 3'b001;
      step(); chk_access("rst_acc", 3'b001, 8'h01);
      reset = 1'b0;
      step(); chk_idle("rst_mid");
      chk("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mid_rdata", 32'(rdata), 32'd0);
      reset = 1'b1; req = 3'b100;
      step(); chk_access("rst_after", 3'b100, 8'h10);
      step(); chk_resp("rst_after", 3'b100, 8'h5A);
      req = 3'b000;
      step(); chk_idle("rst_end");
      $display("[TB] reset during access done");

      // Requester 0 drops req during ACCESS; the ack still arrives.
      req = 3'b011;
      step(); chk_access("drop", 3'b001, 8'h01);
      req = 3'b010;
      step(); chk_resp("drop", 3'b001, 8'h4B);
      step(); chk_idle("drop_gap");
      step(); chk_access("drop_next", 3'b010, 8'h3C);
      step(); chk_resp("drop_next", 3'b010, 8'h76);
      req = 3'b000;
      step(); chk_idle("drop_end");
      $display("[TB] request drop during access done");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
